rib_wb_data_bridge: RTL

Converts the core's single-cycle RIB data-port request (req/we/addr/data, no ack) into a Wishbone classic data-memory transaction with cyc/stb/ack handshake. It stalls the core through the RIB hold input until the transaction completes. It sits between the core's data port and the Controller's second-memory (data_mem_*) bus, replacing the direct stb=req wiring. It adds a bus-timeout watchdog so a missing ack cannot hang the core.

---
 rtl/rib_wb_data_bridge_pkg.sv | 14 +
 rtl/rib_wb_data_bridge_if.sv | 37 +++
 rtl/rib_wb_data_bridge.sv | 99 +++++++++
 3 files changed

// File: rtl/rib_wb_data_bridge_pkg.sv
// Shared types and constants for the RIB-to-Wishbone data-port bridge.
package rib_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;
    localparam logic [31:0] ERR_DATA_DEFAULT       = 32'h0000_0000;
    localparam logic [3:0]  WSTRB_FULL             = 4'hF;

endpackage

// File: rtl/rib_wb_data_bridge_if.sv
// Core data-port (RIB) and Wishbone data-memory signals seen by the bridge.
interface rib_wb_data_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  rib_req_i;
    logic                  rib_we_i;
    logic [ADDR_WIDTH-1:0] rib_addr_i;
    logic [DATA_WIDTH-1:0] rib_data_i;
    logic [DATA_WIDTH-1:0] rib_data_o;
    logic                  rib_hold_o;

    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [3:0]            wb_wstrb_o;
    logic [ADDR_WIDTH-1:0] wb_addr_o;
    logic [DATA_WIDTH-1:0] wb_data_o;
    logic [DATA_WIDTH-1:0] wb_data_i;
    logic                  wb_ack_i;

    // master: the bridge itself; slave: the core plus data memory around it
    modport master (
        input  rib_req_i, rib_we_i, rib_addr_i, rib_data_i,
        output rib_data_o, rib_hold_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_wstrb_o, wb_addr_o, wb_data_o,
        input  wb_data_i, wb_ack_i
    );

    modport slave (
        output rib_req_i, rib_we_i, rib_addr_i, rib_data_i,
        input  rib_data_o, rib_hold_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_wstrb_o, wb_addr_o, wb_data_o,
        output wb_data_i, wb_ack_i
    );

endinterface

// File: rtl/rib_wb_data_bridge.sv
// Turns a single-cycle RIB data request into one Wishbone classic cycle,
// stalling the core until ack (or a watchdog abort) completes it.
//
// state | meaning
// IDLE  | no transaction; hold follows req, request captured on req
// BUS   | cyc/stb asserted with captured addr/data/we; waiting for ack
// DONE  | one cycle presenting latched read data (or ERR_DATA) to core
module rib_wb_data_bridge
    import rib_wb_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int unsigned           TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    rib_wb_data_bridge_if.master bus,
    output logic                 err_o,
    output logic                 busy_o
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUS  = BUS;
    localparam logic [1:0] S_DONE = DONE;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [1:0]            state;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [CNT_W-1:0]      cnt;
    logic                  err_q;
    logic                  timeout_hit;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.rib_req_i) begin
                        we_q    <= bus.rib_we_i;
                        addr_q  <= bus.rib_addr_i;
                        wdata_q <= bus.rib_data_i;
                        state   <= S_BUS;
                    end
                end
                S_BUS: begin
                    // ack takes priority over a watchdog expiry in the same cycle
                    if (bus.wb_ack_i) begin
                        rdata_q <= bus.wb_data_i;
                        cnt     <= '0;
                        state   <= S_DONE;
                    end else if (timeout_hit) begin
                        rdata_q <= ERR_DATA;
                        err_q   <= 1'b1;
                        cnt     <= '0;
                        state   <= S_DONE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.wb_cyc_o   = (state == S_BUS);
    assign bus.wb_stb_o   = (state == S_BUS);
    assign bus.wb_we_o    = we_q;
    assign bus.wb_wstrb_o = WSTRB_FULL;
    assign bus.wb_addr_o  = addr_q;
    assign bus.wb_data_o  = wdata_q;

    // reset gates hold so a stalled core is released the instant rst rises
    assign bus.rib_hold_o = !rst && ((state == S_BUS) ||
                                     ((state == S_IDLE) && bus.rib_req_i));
    assign bus.rib_data_o = (state == S_DONE) ? rdata_q : '0;

    assign err_o  = err_q;
    assign busy_o = (state != S_IDLE);

endmodule
